// File: rtl/redmule_mx_pkg.sv
// Shared types and constants for the RedMulE MX multi-format decoder.
// Covers the FP8 element formats, E8M0 scale encoding and FP16 output encoding.
package redmule_mx_pkg;

  typedef enum logic {
    MX_E4M3 = 1'b0,
    MX_E5M2 = 1'b1
  } mx_fmt_e;

  localparam logic [4:0] E4M3_BIAS = 5'd7;
  localparam logic [4:0] E5M2_BIAS = 5'd15;

  localparam logic [7:0]        E8M0_NAN    = 8'hFF;
  localparam logic signed [9:0] E8M0_BIAS_S = 10'sd127;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_INF  = 16'h7C00;

  // Exponent arithmetic runs at 10-bit signed width throughout.
  localparam logic signed [9:0] FP16_BIAS = 10'sd15;
  localparam logic signed [9:0] FP16_EMAX = 10'sd15;
  localparam logic signed [9:0] FP16_EMIN = -10'sd14;

endpackage

// File: rtl/redmule_mx_elem_cvt.sv
// Combinational FP8 (E4M3/E5M2) x E8M0 scale -> FP16 converter for one lane.
// Exact: every FP8 mantissa fits in FP16; out-of-range results saturate to Inf or flush to zero.
module redmule_mx_elem_cvt
  import redmule_mx_pkg::*;
(
  input  logic [7:0]  elem_i,
  input  logic [7:0]  scale_i,
  input  mx_fmt_e     fmt_i,
  output logic [15:0] fp16_o
);

  logic              sign;
  logic [4:0]        exp_f;
  logic [2:0]        man_f;
  logic [4:0]        bias;
  logic              is_nan;
  logic              is_inf;
  logic              is_zero;
  logic [1:0]        lead_sh;
  logic [2:0]        frac_sub;
  logic [2:0]        frac_n;
  logic signed [9:0] e_elem;
  logic signed [9:0] e_res;

  // E5M2 mantissa is padded to 3 bits so both formats share one datapath.
  always_comb begin
    sign = elem_i[7];
    if (fmt_i == MX_E5M2) begin
      exp_f  = elem_i[6:2];
      man_f  = {elem_i[1:0], 1'b0};
      bias   = E5M2_BIAS;
      is_nan = (exp_f == 5'h1F) && (man_f != 3'b000);
      is_inf = (exp_f == 5'h1F) && (man_f == 3'b000);
    end else begin
      exp_f  = {1'b0, elem_i[6:3]};
      man_f  = elem_i[2:0];
      bias   = E4M3_BIAS;
      is_nan = (elem_i[6:0] == 7'h7F);
      is_inf = 1'b0;
    end
    is_zero = (exp_f == 5'd0) && (man_f == 3'b000);
  end

  always_comb begin
    lead_sh  = 2'd3;
    frac_sub = 3'b000;
    if (man_f[2]) begin
      lead_sh  = 2'd1;
      frac_sub = {man_f[1:0], 1'b0};
    end else if (man_f[1]) begin
      lead_sh  = 2'd2;
      frac_sub = {man_f[0], 2'b00};
    end
  end

  always_comb begin
    if (exp_f == 5'd0) begin
      e_elem = 10'sd1 - $signed({5'b0, bias}) - $signed({8'b0, lead_sh});
      frac_n = frac_sub;
    end else begin
      e_elem = $signed({5'b0, exp_f}) - $signed({5'b0, bias});
      frac_n = man_f;
    end
    e_res = e_elem + $signed({2'b0, scale_i}) - E8M0_BIAS_S;
  end

  // Zero must be resolved before the range checks: a huge scale must not turn 0 into Inf.
  always_comb begin
    if ((scale_i == E8M0_NAN) || is_nan) begin
      fp16_o = FP16_QNAN;
    end else if (is_inf) begin
      fp16_o = FP16_INF | {sign, 15'b0};
    end else if (is_zero) begin
      fp16_o = {sign, 15'b0};
    end else if (e_res > FP16_EMAX) begin
      fp16_o = FP16_INF | {sign, 15'b0};
    end else if (e_res < FP16_EMIN) begin
      fp16_o = {sign, 15'b0};
    end else begin
      fp16_o = {sign, 5'(e_res + FP16_BIAS), frac_n, 7'b0};
    end
  end

endmodule

// File: rtl/redmule_mx_multifmt_decoder.sv
// MX block decoder: accepts one FP8 element word plus shared E8M0 scale per handshake
// and streams it out as FP16, NUM_LANES per beat, with a last flag and zero-bubble restart.
module redmule_mx_multifmt_decoder
  import redmule_mx_pkg::*;
#(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BITW      = 16,
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      fmt_i,
  input  logic                      mx_val_valid_i,
  output logic                      mx_val_ready_o,
  input  logic [DATA_W-1:0]         mx_val_data_i,
  input  logic                      mx_exp_valid_i,
  output logic                      mx_exp_ready_o,
  input  logic [7:0]                mx_exp_data_i,
  output logic                      fp16_valid_o,
  input  logic                      fp16_ready_i,
  output logic [NUM_LANES*BITW-1:0] fp16_data_o,
  output logic                      fp16_last_o,
  output logic                      busy_o
);

  localparam int unsigned NUM_ELEMS = DATA_W / 8;
  localparam int unsigned NUM_BEATS = NUM_ELEMS / NUM_LANES;
  localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  if (BITW != 16) begin : g_bitw_chk
    $error("redmule_mx_multifmt_decoder: BITW must be 16 (FP16 output only)");
  end
  if ((DATA_W % 8) != 0) begin : g_dataw_chk
    $error("redmule_mx_multifmt_decoder: DATA_W must be a multiple of 8");
  end
  if ((NUM_ELEMS % NUM_LANES) != 0) begin : g_lanes_chk
    $error("redmule_mx_multifmt_decoder: NUM_ELEMS must be a multiple of NUM_LANES");
  end

  typedef struct packed {
    mx_fmt_e           fmt;
    logic [7:0]        scale;
    logic [DATA_W-1:0] data;
  } mx_blk_t;

  logic [0:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  mx_blk_t           blk_q, blk_d;

  logic streaming;
  logic last_beat;
  logic beat_fire;
  logic can_accept;
  logic accept;

  logic [NUM_BEATS-1:0][NUM_LANES-1:0][7:0] elems;
  logic [NUM_LANES-1:0][BITW-1:0]           lane_fp16;

  assign streaming = (state_q == STREAM);
  assign last_beat = streaming && (beat_q == LAST_BEAT);
  assign beat_fire = streaming && fp16_ready_i;

  // Each channel's ready depends on the other's valid so both are consumed in the same cycle.
  assign can_accept     = !clear_i && (!streaming || (last_beat && fp16_ready_i));
  assign mx_val_ready_o = can_accept && mx_exp_valid_i;
  assign mx_exp_ready_o = can_accept && mx_val_valid_i;
  assign accept         = can_accept && mx_val_valid_i && mx_exp_valid_i;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    blk_d   = blk_q;
    if (clear_i) begin
      state_d = IDLE;
      beat_d  = '0;
    end else if (accept) begin
      state_d     = STREAM;
      beat_d      = '0;
      blk_d.fmt   = mx_fmt_e'(fmt_i);
      blk_d.scale = mx_exp_data_i;
      blk_d.data  = mx_val_data_i;
    end else if (beat_fire) begin
      if (last_beat) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
    end
  end

  assign elems = blk_q.data;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    redmule_mx_elem_cvt u_cvt (
      .elem_i  (elems[beat_q][l]),
      .scale_i (blk_q.scale),
      .fmt_i   (blk_q.fmt),
      .fp16_o  (lane_fp16[l])
    );
  end

  assign fp16_data_o  = lane_fp16;
  assign fp16_valid_o = streaming;
  assign fp16_last_o  = last_beat;
  assign busy_o       = streaming;

endmodule

// File: tb/tb_redmule_mx_multifmt_decoder.sv
// Directed bench for the MX multi-format decoder: conversion vectors, backpressure,
// back-to-back blocks, lone-valid handshake, clear and asynchronous reset.
module tb_redmule_mx_multifmt_decoder;

  localparam int DATA_W    = 256;
  localparam int BITW      = 16;
  localparam int NUM_LANES = 4;
  localparam int NUM_ELEMS = DATA_W / 8;
  localparam int NUM_BEATS = NUM_ELEMS / NUM_LANES;

  typedef logic [NUM_BEATS-1:0][NUM_LANES*BITW-1:0] blk_t;
  typedef struct {
    logic        f;
    logic [7:0]  x;
    logic [7:0]  e;
    logic [15:0] y;
  } vec_t;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic                      clear_i;
  logic                      fmt_i;
  logic                      mx_val_valid_i;
  logic                      mx_val_ready_o;
  logic [DATA_W-1:0]         mx_val_data_i;
  logic                      mx_exp_valid_i;
  logic                      mx_exp_ready_o;
  logic [7:0]                mx_exp_data_i;
  logic                      fp16_valid_o;
  logic                      fp16_ready_i;
  logic [NUM_LANES*BITW-1:0] fp16_data_o;
  logic                      fp16_last_o;
  logic                      busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  redmule_mx_multifmt_decoder #(
    .DATA_W    (DATA_W),
    .BITW      (BITW),
    .NUM_LANES (NUM_LANES)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .fmt_i          (fmt_i),
    .mx_val_valid_i (mx_val_valid_i),
    .mx_val_ready_o (mx_val_ready_o),
    .mx_val_data_i  (mx_val_data_i),
    .mx_exp_valid_i (mx_exp_valid_i),
    .mx_exp_ready_o (mx_exp_ready_o),
    .mx_exp_data_i  (mx_exp_data_i),
    .fp16_valid_o   (fp16_valid_o),
    .fp16_ready_i   (fp16_ready_i),
    .fp16_data_o    (fp16_data_o),
    .fp16_last_o    (fp16_last_o),
    .busy_o         (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] fill(input logic [7:0] b, input int odd, input logic [7:0] ob);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < NUM_ELEMS; i++) v[8*i +: 8] = (i == odd) ? ob : b;
    return v;
  endfunction

  function automatic blk_t ufill(input logic [15:0] y, input int odd, input logic [15:0] oy);
    blk_t v;
    for (int i = 0; i < NUM_ELEMS; i++) v[i/NUM_LANES][16*(i%NUM_LANES) +: 16] = (i == odd) ? oy : y;
    return v;
  endfunction

  // Element 4k+l = 0x38+8k+l (E4M3, X=127) decodes to 0x3C00 + 0x400*k + 0x80*l.
  function automatic logic [DATA_W-1:0] ramp_d();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < NUM_ELEMS; i++) v[8*i +: 8] = 8'(8'h38 + 8*(i/NUM_LANES) + (i%NUM_LANES));
    return v;
  endfunction

  function automatic blk_t ramp_y();
    blk_t v;
    for (int i = 0; i < NUM_ELEMS; i++)
      v[i/NUM_LANES][16*(i%NUM_LANES) +: 16] = 16'(16'h3C00 + 16'h0400*(i/NUM_LANES) + 16'h0080*(i%NUM_LANES));
    return v;
  endfunction

  task automatic offer(input logic [DATA_W-1:0] d, input logic [7:0] x, input logic f, input string tag);
    int n = 0;
    mx_val_data_i  = d;
    mx_exp_data_i  = x;
    fmt_i          = f;
    mx_val_valid_i = 1'b1;
    mx_exp_valid_i = 1'b1;
    #1;
    while (!(mx_val_ready_o && mx_exp_ready_o) && n < 50) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk({tag, " accept"}, 64'({mx_val_ready_o, mx_exp_ready_o}), 64'h3);
    @(negedge clk_i);
    mx_val_valid_i = 1'b0;
    mx_exp_valid_i = 1'b0;
  endtask

  task automatic drain(input blk_t eb, input bit bp, input int nb, input string tag);
    int k   = 0;
    int cyc = 0;
    while (k < nb && cyc < 200) begin
      fp16_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk({tag, " valid"}, 64'(fp16_valid_o), 64'd1);
      chk({tag, " data"}, fp16_data_o, eb[k]);
      chk({tag, " last"}, 64'(fp16_last_o), 64'(k == NUM_BEATS - 1));
      if (fp16_valid_o && fp16_ready_i) k++;
      cyc++;
      @(negedge clk_i);
    end
    fp16_ready_i = 1'b0;
    chk({tag, " beats"}, 64'(k), 64'(nb));
    if (nb == NUM_BEATS) begin
      #1;
      chk({tag, " done"}, 64'(fp16_valid_o), 64'd0);
    end
  endtask

  vec_t tbl [18] = '{
    '{1'b0, 8'd127, 8'h38, 16'h3C00},
    '{1'b0, 8'd128, 8'h38, 16'h4000},
    '{1'b1, 8'd127, 8'h3C, 16'h3C00},
    '{1'b1, 8'd127, 8'h7C, 16'h7C00},
    '{1'b1, 8'd127, 8'h7D, 16'h7E00},
    '{1'b1, 8'd127, 8'h00, 16'h0000},
    '{1'b1, 8'd127, 8'h80, 16'h8000},
    '{1'b0, 8'd135, 8'h7E, 16'h7C00},
    '{1'b0, 8'd134, 8'h7E, 16'h7B00},
    '{1'b0, 8'd127, 8'h01, 16'h1800},
    '{1'b0, 8'd117, 8'h01, 16'h0000},
    '{1'b0, 8'd122, 8'h01, 16'h0400},
    '{1'b0, 8'd127, 8'h7F, 16'h7E00},
    '{1'b0, 8'hFF,  8'h38, 16'h7E00},
    '{1'b1, 8'hFF,  8'h00, 16'h7E00},
    '{1'b0, 8'd127, 8'hFE, 16'hDF00},
    '{1'b0, 8'd127, 8'h06, 16'h2200},
    '{1'b1, 8'd129, 8'h01, 16'h0400}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    blk_t rb;
    rb             = ramp_y();
    rst_ni         = 1'b0;
    clear_i        = 1'b0;
    fmt_i          = 1'b0;
    mx_val_valid_i = 1'b0;
    mx_exp_valid_i = 1'b0;
    mx_val_data_i  = '0;
    mx_exp_data_i  = '0;
    fp16_ready_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst valid", 64'(fp16_valid_o), 64'd0);
    chk("rst last", 64'(fp16_last_o), 64'd0);
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst readies", 64'({mx_val_ready_o, mx_exp_ready_o}), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 18; i++) begin
      offer(fill(tbl[i].e, -1, 8'h00), tbl[i].x, tbl[i].f, $sformatf("vec%0d", i));
      drain(ufill(tbl[i].y, -1, 16'h0), (i % 3) == 0, NUM_BEATS, $sformatf("vec%0d", i));
    end

    offer(fill(8'h38, 5, 8'hB8), 8'd127, 1'b0, "neg");
    drain(ufill(16'h3C00, 5, 16'hBC00), 1'b0, NUM_BEATS, "neg");

    offer(ramp_d(), 8'd127, 1'b0, "bp");
    drain(rb, 1'b1, NUM_BEATS, "bp");

    // Back-to-back: second block waits on the inputs and must follow with no gap.
    @(negedge clk_i);
    fp16_ready_i   = 1'b1;
    mx_val_data_i  = ramp_d();
    mx_exp_data_i  = 8'd127;
    fmt_i          = 1'b0;
    mx_val_valid_i = 1'b1;
    mx_exp_valid_i = 1'b1;
    #1;
    chk("b2b acceptA", 64'(mx_val_ready_o), 64'd1);
    @(negedge clk_i);
    mx_val_data_i = fill(8'h38, -1, 8'h00);
    mx_exp_data_i = 8'd128;
    for (int c = 0; c < 2*NUM_BEATS; c++) begin
      #1;
      chk("b2b valid", 64'(fp16_valid_o), 64'd1);
      chk("b2b data", fp16_data_o, (c < NUM_BEATS) ? rb[c] : {NUM_LANES{16'h4000}});
      chk("b2b last", 64'(fp16_last_o), 64'((c % NUM_BEATS) == NUM_BEATS - 1));
      chk("b2b ready", 64'(mx_val_ready_o), 64'(c == NUM_BEATS - 1));
      @(negedge clk_i);
      if (c == NUM_BEATS - 1) begin
        mx_val_valid_i = 1'b0;
        mx_exp_valid_i = 1'b0;
      end
    end
    #1;
    chk("b2b done", 64'(fp16_valid_o), 64'd0);
    fp16_ready_i = 1'b0;

    // A lone element valid must never be consumed.
    @(negedge clk_i);
    mx_val_valid_i = 1'b1;
    mx_val_data_i  = fill(8'h38, -1, 8'h00);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("lone ready", 64'(mx_val_ready_o), 64'd0);
      chk("lone busy", 64'(busy_o), 64'd0);
      @(negedge clk_i);
    end
    mx_val_valid_i = 1'b0;
    #1;
    chk("lone valid", 64'(fp16_valid_o), 64'd0);

    offer(ramp_d(), 8'd127, 1'b0, "clr");
    drain(rb, 1'b0, 3, "clr");
    #1;
    chk("clr beat3", fp16_data_o, rb[3]);
    clear_i        = 1'b1;
    mx_val_valid_i = 1'b1;
    mx_exp_valid_i = 1'b1;
    mx_val_data_i  = fill(8'h38, -1, 8'h00);
    #1;
    chk("clr readies", 64'({mx_val_ready_o, mx_exp_ready_o}), 64'd0);
    @(negedge clk_i);
    clear_i        = 1'b0;
    mx_val_valid_i = 1'b0;
    mx_exp_valid_i = 1'b0;
    #1;
    chk("clr valid", 64'(fp16_valid_o), 64'd0);
    chk("clr busy", 64'(busy_o), 64'd0);
    offer(ramp_d(), 8'd127, 1'b0, "post_clr");
    drain(rb, 1'b0, NUM_BEATS, "post_clr");

    offer(ramp_d(), 8'd127, 1'b0, "rst");
    drain(rb, 1'b0, NUM_BEATS - 1, "rst");
    #1;
    chk("rst pre last", 64'(fp16_last_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst mid valid", 64'(fp16_valid_o), 64'd0);
    chk("rst mid last", 64'(fp16_last_o), 64'd0);
    chk("rst mid busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    offer(ramp_d(), 8'd127, 1'b0, "post_rst");
    drain(rb, 1'b0, NUM_BEATS, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/redmule_mx_multifmt_decoder.md
Name: redmule_mx_multifmt_decoder

Overview:
Parametrised successor of the RedMulE MX decoder. Accepts one MX block per handshake (a packed word of FP8 elements plus one shared E8M0 scale). Emits the block as FP16 values, NUM_LANES per beat, and raises a last flag on the final beat. Adds a runtime element-format select (E4M3/E5M2), explicit overflow/underflow/NaN rules, a last marker, a synchronous clear and zero-bubble back-to-back blocks. Sits between the streamer's MX load path and the FP16 datapath.

Parameters:
DATA_W, 256, width of packed element word; NUM_ELEMS = DATA_W/8
BITW, 16, output element width (FP16 only; elaboration error otherwise)
NUM_LANES, 4, FP16 outputs per beat; NUM_ELEMS % NUM_LANES == 0 checked at elaboration
NUM_BEATS, NUM_ELEMS/NUM_LANES, derived localparam

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous abort; drops current block
fmt_i  in  1  element format: 0 = E4M3 (bias 7), 1 = E5M2 (bias 15); sampled at block accept
mx_val_valid_i  in  1  element word valid
mx_val_ready_o  out  1  element word ready
mx_val_data_i  in  DATA_W  element i at bits [8i+7:8i]
mx_exp_valid_i  in  1  shared scale valid
mx_exp_ready_o  out  1  shared scale ready
mx_exp_data_i  in  8  E8M0 scale X; value 2^(X-127)
fp16_valid_o  out  1  beat valid
fp16_ready_i  in  1  beat accepted downstream
fp16_data_o  out  NUM_LANES*BITW  lane l = element beat*NUM_LANES+l
fp16_last_o  out  1  high on final beat of a block
busy_o  out  1  block held

Behaviour:
- Reset: fp16_valid_o=0, fp16_last_o=0, busy_o=0, beat counter=0, block registers=0. Ready outputs follow the combinational rule below.
- States: IDLE (no block) and STREAM (block held, beat_q in 0..NUM_BEATS-1).
- can_accept = IDLE | (STREAM & beat_q==NUM_BEATS-1 & fp16_ready_i).
- mx_val_ready_o = can_accept & mx_exp_valid_i; mx_exp_ready_o = can_accept & mx_val_valid_i. This makes the two channels consume atomically; a lone valid is never consumed.
- Accept cycle: register data word, scale and fmt_i. Go to STREAM with beat_q=0. The first beat is valid the next cycle (latency 1).
- In STREAM: fp16_valid_o=1. fp16_data_o is derived combinationally from the registers by indexing beat_q. On valid&ready, beat_q increments. When fp16_ready_i is low, data and beat_q hold stable.
- Final beat handshake: if a new block is accepted in the same cycle, go to STREAM with beat_q=0 (no bubble). Otherwise go to IDLE.
- fp16_last_o = STREAM & beat_q==NUM_BEATS-1.
- clear_i: next state IDLE, beat_q=0, valid drops next cycle. clear_i forces both readies low. It has priority over everything else.
- Per-element conversion, applied per lane:
  - X==0xFF: output 0x7E00.
  - E4M3 S.1111.111 = NaN: output 0x7E00. E4M3 has no Inf.
  - E5M2 exp 31: mant 0 gives ±Inf (0x7C00|S<<15); mant≠0 gives 0x7E00.
  - Zero (exp=0, mant=0): ±0, sign preserved.
  - FP8 subnormal: normalise with a leading-one shift. Unbiased exponent = 1-bias-shift.
  - e = e_elem + X - 127, computed at 10-bit signed width.
  - e > 15: ±Inf. e < -14: ±0 (flush-to-zero, no FP16 subnormal output). Otherwise FP16 exp = e+15.
  - Mantissa is left-aligned into 10 bits with zero padding. Conversion is exact, so no rounding is needed.

Decomposition:
- Package redmule_mx_pkg holds: mx_fmt_e enum {MX_E4M3, MX_E5M2}; bias constants; E8M0_NAN=8'hFF; FP16_QNAN=16'h7E00; FP16_INF=16'h7C00; FP16 bias and min/max exponent constants.
- Sub-module redmule_mx_elem_cvt: purely combinational. Inputs are 8-bit element, 8-bit scale and fmt; output is 16-bit FP16. Instantiated NUM_LANES times. The top level holds the FSM, registers and handshake.

Test Plan:
- E4M3 with X=127, block all 0x38 (one element 0xB8) -> every lane 0x3C00 (that element 0xBC00), 8 beats, fp16_last_o only on beat 8. With X=128 -> 0x4000.
- E5M2 with X=127: element 0x3C -> 0x3C00; 0x7C -> 0x7C00; 0x7D -> 0x7E00; 0x00 -> 0x0000; 0x80 -> 0x8000.
- E4M3 boundaries: 0x7E with X=135 -> 0x7C00 (448·256 overflows); 0x01 with X=127 -> 0x1800; 0x01 with X=117 -> 0x0000; 0x7F -> 0x7E00. Any element with X=0xFF -> 0x7E00.
- Backpressure: toggle fp16_ready_i pseudo-randomly -> data stable while stalled, exactly NUM_BEATS transfers per block, order preserved.
- Back-to-back: both valids held high with two blocks queued and fp16_ready_i=1 -> second block's beat 0 directly follows first block's last beat; no idle cycle.
- Handshake and abort:
  - mx_val_valid_i high alone for 5 cycles -> no consumption, busy_o=0.
  - clear_i at beat 3 -> fp16_valid_o=0 the next cycle; the next block decodes correctly from beat 0.
  - rst_ni asserted mid-block -> all outputs are at their reset values immediately.
